// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide over Dbits cycles, HI/LO result.
// Define MULDIV_DIV_EN to build the divide datapath; without it divide ops complete at once with zero results.
module muldiv_unit #(
    parameter int Dbits = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Dbits-1:0] A,
    input  logic [Dbits-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [Dbits-1:0] hi,
    output logic [Dbits-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(Dbits) + 1;

    if ((Dbits < 4) || ((Dbits % 2) != 0)) begin : g_bad_dbits
        $error("muldiv_unit: Dbits must be even and at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*Dbits-1:0] acc_q, acc_d;
    logic [Dbits-1:0]   opnd_q, opnd_d;
    logic               sp_q, sp_d;
    logic [Dbits-1:0]   hi_q, hi_d;
    logic [Dbits-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, done_q;

    logic               a_neg, b_neg;
    logic [Dbits-1:0]   a_mag, b_mag;
    logic [Dbits:0]     sum;
`ifdef MULDIV_DIV_EN
    logic               div_q, div_d;
    logic               sr_q, sr_d;
    logic [Dbits:0]     shifted, trial;
`endif

    assign a_neg = op[0] & A[Dbits-1];
    assign b_neg = op[0] & B[Dbits-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sp_d    = sp_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        sum     = '0;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
        sr_d    = sr_q;
        shifted = '0;
        trial   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    sp_d  = a_neg ^ b_neg;
                    if (op[1]) begin
`ifdef MULDIV_DIV_EN
                        div_d  = 1'b1;
                        sr_d   = a_neg;
                        acc_d  = {{Dbits{1'b0}}, a_mag};
                        opnd_d = b_mag;
                        if (B == '0) begin
                            state_d = S_DONE;
                            hi_d    = A;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
`else
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        dbz_d   = 1'b0;
`endif
                    end else begin
`ifdef MULDIV_DIV_EN
                        div_d = 1'b0;
                        sr_d  = 1'b0;
`endif
                        // multiplier sits in the low half and is consumed LSB first
                        acc_d   = {{Dbits{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    shifted = acc_q[2*Dbits-1:Dbits-1];
                    trial   = shifted - {1'b0, opnd_q};
                    if (!trial[Dbits]) begin
                        acc_d = {trial[Dbits-1:0], acc_q[Dbits-2:0], 1'b1};
                    end else begin
                        acc_d = {shifted[Dbits-1:0], acc_q[Dbits-2:0], 1'b0};
                    end
                end else begin
                    sum   = {1'b0, acc_q[2*Dbits-1:Dbits]}
                          + (acc_q[0] ? {1'b0, opnd_q} : {(Dbits+1){1'b0}});
                    acc_d = {sum, acc_q[Dbits-1:1]};
                end
`else
                sum   = {1'b0, acc_q[2*Dbits-1:Dbits]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(Dbits+1){1'b0}});
                acc_d = {sum, acc_q[Dbits-1:1]};
`endif
                if (cnt_q == CW'(Dbits - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    lo_d = sp_q ? -acc_q[Dbits-1:0] : acc_q[Dbits-1:0];
                    hi_d = sr_q ? -acc_q[2*Dbits-1:Dbits] : acc_q[2*Dbits-1:Dbits];
                end else begin
                    {hi_d, lo_d} = sp_q ? -acc_q : acc_q;
                end
`else
                {hi_d, lo_d} = sp_q ? -acc_q : acc_q;
`endif
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sp_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            sr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sp_q    <= sp_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
            sr_q    <= sr_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-result queue; honours MULDIV_DIV_EN like the design.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A, B;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;
    int done_pulses = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t scb[$];

    muldiv_unit #(.Dbits(W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .dbz    (dbz)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        longint       sa, sbv, q, r;
        logic [63:0]  p;
        e.dbz = 1'b0;
        e.lat = W + 1;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        p     = '0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'b00: begin
                p = 64'(a) * 64'(b);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
`ifdef MULDIV_DIV_EN
            default: begin
                if (b == '0) begin
                    e.hi  = a;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                    e.lat = 0;
                end else if (o == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
`else
            default: begin
                e.lat = 0;
            end
`endif
        endcase
        return e;
    endfunction

    // Leaves the bench 1 time unit after the edge that sampled start.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit expect_done);
        @(posedge clock); #1;
        start = 1'b1; op = o; A = a; B = b;
        if (expect_done) scb.push_back(model(o, a, b));
        @(posedge clock); #1;
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_op(input string tag, input int n0);
        exp_t         e;
        int           n;
        bit           held;
        logic [W-1:0] hi0, lo0;
        n = n0; held = 1'b1; hi0 = hi; lo0 = lo;
        while (done !== 1'b1 && n < 100) begin
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        if (scb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = scb.pop_front();
        check({tag, "_hold"}, held, 1);
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_done"}, done, 1);
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
        check({tag, "_dbz"}, dbz, e.dbz);
        @(posedge clock); #1;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(o, a, b, 1'b1);
        finish_op(tag, 0);
    endtask

    initial begin
        int p0;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_dbz", dbz, 0);
        reset_n = 1'b1;

        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7);
        run("mult_7xneg3", 2'b01, 32'd7, 32'hFFFF_FFFD);
        run("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000);
        run("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2);
        run("div_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE);
        run("divu_100by7", 2'b10, 32'd100, 32'd7);
        run("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run("divu_by_zero", 2'b10, 32'd5, 32'd0);
        run("multu_2x3", 2'b00, 32'd2, 32'd3);
        run("div_by_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0);
        for (int i = 0; i < 8; i++) begin
            run("rand", 2'(i % 4), $urandom, $urandom);
        end

        // start pulse while busy must be dropped
        p0 = done_pulses;
        start_op(2'b00, 32'd3, 32'd4, 1'b1);
        repeat (3) begin @(posedge clock); #1; end
        start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        finish_op("busy_ignore", 4);
        repeat (40) @(posedge clock);
        #1;
        check("busy_ignore_pulses", done_pulses - p0, 1);
        check("busy_ignore_lo_kept", lo, 12);
        check("busy_ignore_busy", busy, 0);

        // reset part-way through RUN
        p0 = done_pulses;
        start_op(2'b00, 32'h1234, 32'h5678, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("midreset_no_done", done_pulses - p0, 0);
        run("after_reset", 2'b00, 32'd1000, 32'd1000);

        // reset wins over start on the same edge
        @(posedge clock); #1;
        reset_n = 1'b0; start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd5;
        @(posedge clock); #1;
        start = 1'b0; reset_n = 1'b1;
        check("reset_prio_busy", busy, 0);
        check("reset_prio_lo", lo, 0);
        run("after_prio", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RISC231 datapath. Consumes the two register-file read operands on a one-cycle `start` pulse from the execute stage, runs a shift-add multiply or restoring divide over `Dbits` cycles, and holds the 2·`Dbits` result in HI/LO registers. The control unit stalls on `busy` and moves HI/LO to the register-file write port once `done` pulses.

## Interface
- `Dbits`, 32, operand and result half-width; must be ≥ 4 and even.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  2  operation select: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- `A`  in  `Dbits`  operand 1 (ReadData1); multiplicand or dividend.
- `B`  in  `Dbits`  operand 2 (ReadData2); multiplier or divisor.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`dbz` are valid from this cycle on.
- `hi`  out  `Dbits`  product upper half, or remainder.
- `lo`  out  `Dbits`  product lower half, or quotient.
- `dbz`  out  1  divide-by-zero flag for the last completed op; held until the next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - `start`=1 captures `A`, `B` and `op` into internal registers. Operands may change freely afterwards.
  - For signed ops, operands are converted to magnitudes and the result signs are latched: product/quotient sign = sA^sB, remainder sign = sA.
  - Next state is RUN, except a divide with `B`=0, which goes directly to DONE.
- RUN:
  - Exactly `Dbits` iterations, one per cycle, tracked by a counter of `$clog2(Dbits)+1` bits.
  - Multiply: one add-and-shift step per cycle over a 2·`Dbits` accumulator.
  - Divide: restoring shift-subtract per cycle, producing one quotient bit each step.
  - When the counter reaches `Dbits`, next state is FIX.
- FIX:
  - Applies two's-complement sign correction to the signed results.
  - Writes `hi`/`lo` and `dbz`=0. Next state is DONE.
- DONE: `done`=1 for this single cycle. Next state is IDLE.
- Divide by zero: `hi`=`A` as captured, `lo`=all ones, `dbz`=1. These are written on the IDLE→DONE edge.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): `lo`=0x80000000, `hi`=0, `dbz`=0. This falls out of magnitude arithmetic; it is not a special case.
- `start` while `busy`=1 is ignored. There is no queueing.
- `hi`/`lo` change only on the FIX→DONE or IDLE→DONE edge. They stay stable at all other times, including throughout RUN.
- Illegal parameter values (odd `Dbits` or `Dbits` < 4) are a compile-time error, enforced with an elaboration `$error`.

## Timing
- Reset (`reset_n`=0 at an edge) forces: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `dbz`=0, counter 0.
- Reset during RUN or FIX aborts the operation, and the partial result is discarded.
- Reset has priority over `start` on the same edge.
- Normal op, start sampled at edge k:
  - `busy`=1 from edge k.
  - FIX is entered at edge k+`Dbits`.
  - `hi`/`lo` are written at edge k+`Dbits`+1.
  - `done`=1 in the cycle between edges k+`Dbits`+1 and k+`Dbits`+2.
  - IDLE is re-entered at edge k+`Dbits`+2.
  - With `Dbits`=32, start-to-done latency is 33 cycles.
- Divide by zero, start at edge k: results written at edge k, `done` high in the next cycle, IDLE at edge k+1.
- Earliest back-to-back `start` sample: the first edge after returning to IDLE, i.e. edge k+`Dbits`+3 for a normal op.
- `busy` and `done` are registered outputs with no combinational path from `start`.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Full divide datapath as described above.
- `MULDIV_DIV_EN` undefined:
  - Divide hardware is removed.
  - op 10/11 goes IDLE→DONE with `hi`=0, `lo`=0, `dbz`=0, using the divide-by-zero timing.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 cycles after start; `busy` deasserts one cycle later.
- MULT with A=0xFFFFFFFD (−3), B=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (−21); then MULT 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV with A=0xFFFFFFF9 (−7), B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 100/7 → `lo`=14, `hi`=2; DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `dbz`=0.
- DIVU with A=5, B=0 → `done` one cycle after start, `hi`=5, `lo`=0xFFFFFFFF, `dbz`=1; a following MULTU 2×3 clears `dbz` and gives `lo`=6.
- Start MULTU 3×4, then pulse `start` with A=9, B=9 during RUN → second request ignored; result is `lo`=12 and exactly one `done` pulse.
- Start a multiply, assert `reset_n`=0 at cycle 10 → `busy`=0, `hi`=`lo`=0 on the next cycle, and no `done` pulse; a subsequent op completes normally.
